// File: rtl/xxhash_pkg.sv
// Shared definitions for the xxhash64 feeder slice.
// Contents: WORD_SIZE, the 64-bit core word type and the feeder state enum.
package xxhash_pkg;

  localparam int WORD_SIZE = 64;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/xxhash64_feeder_if.sv
// Bundle of every non-clock signal of the xxhash64 feeder.
// Ports (grouped):
//   seed channel   : seed_valid, seed, seed_empty -> ; <- seed_ready
//   byte stream    : s_valid, s_data, s_last -> ; <- s_ready
//   core side      : <- seed_in, add_to_hash, request_hash, input_bytes, word_bytes
//                    hash_ready, output_hash ->
//   result channel : <- res_valid, res_hash, res_len ; res_ready ->
// Modport slave is taken by the feeder, master by whatever surrounds it.
interface xxhash64_feeder_if #(
  parameter int IN_BYTES = 1,
  parameter int LEN_W    = 64
);
  import xxhash_pkg::*;

  logic                  seed_valid;
  word_t                 seed;
  logic                  seed_empty;
  logic                  seed_ready;
  logic                  s_valid;
  logic [8*IN_BYTES-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;
  logic                  seed_in;
  logic                  add_to_hash;
  logic                  request_hash;
  word_t                 input_bytes;
  logic [3:0]            word_bytes;
  logic                  hash_ready;
  word_t                 output_hash;
  logic                  res_valid;
  word_t                 res_hash;
  logic [LEN_W-1:0]      res_len;
  logic                  res_ready;

  modport slave (
    input  seed_valid, seed, seed_empty, s_valid, s_data, s_last,
           hash_ready, output_hash, res_ready,
    output seed_ready, s_ready, seed_in, add_to_hash, request_hash,
           input_bytes, word_bytes, res_valid, res_hash, res_len
  );

  modport master (
    output seed_valid, seed, seed_empty, s_valid, s_data, s_last,
           hash_ready, output_hash, res_ready,
    input  seed_ready, s_ready, seed_in, add_to_hash, request_hash,
           input_bytes, word_bytes, res_valid, res_hash, res_len
  );

endinterface

// File: rtl/xxhash_byte_packer.sv
// Little-endian beat-to-word packer.
// Keeps the partially filled 64-bit word and its fill count. For the beat
// being accepted this cycle it presents the merged word, its valid byte count
// and whether that beat completes a word (full word or last beat). The
// caller registers the word; the buffer is cleared on the same edge.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   beat_fire     a beat is accepted this cycle
//   beat_data     beat payload, byte 0 in [7:0]
//   beat_last     accepted beat ends the message
//   word_done     merged word must be emitted
//   word          buffer merged with the current beat, unused bytes zero
//   word_bytes    valid bytes in word (1..8)
module xxhash_byte_packer
  import xxhash_pkg::*;
#(
  parameter int IN_BYTES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_fire,
  input  logic [8*IN_BYTES-1:0] beat_data,
  input  logic                  beat_last,
  output logic                  word_done,
  output word_t                 word,
  output logic [3:0]            word_bytes
);

  localparam logic [3:0] BEAT_BYTES = 4'(IN_BYTES);

  logic [3:0] fill_q, fill_d;
  word_t      pack_q, pack_d;
  logic [3:0] fill_sum_s;
  word_t      beat_word_s;

  // Merge the incoming beat at the current fill offset and update the buffer.
  always_comb begin
    fill_sum_s  = fill_q + BEAT_BYTES;
    beat_word_s = word_t'(beat_data) << {fill_q, 3'b000};
    word        = pack_q | beat_word_s;
    word_bytes  = fill_sum_s;
    word_done   = beat_fire && (beat_last || (fill_sum_s == 4'd8));
    pack_d      = pack_q;
    fill_d      = fill_q;
    if (word_done) begin
      pack_d = {WORD_SIZE{1'b0}};
      fill_d = 4'd0;
    end else if (beat_fire) begin
      pack_d = word;
      fill_d = fill_sum_s;
    end else begin
      pack_d = pack_q;
      fill_d = fill_q;
    end
  end

  // Pack buffer and fill count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_q <= {WORD_SIZE{1'b0}};
      fill_q <= 4'd0;
    end else begin
      pack_q <= pack_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/xxhash64_feeder.sv
// Upstream feeder of the xxhash64 core.
// Takes one seed per message, then a valid/ready byte stream with a last
// flag, packs it little-endian into 64-bit words and drives the core strobes
// (seed_in / add_to_hash / request_hash). The core result is captured and
// offered on a valid/ready result port together with the message length.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset; discards any message in flight
//   bus  xxhash64_feeder_if.slave: seed, stream, core and result channels
// All core-side and result outputs come straight from flops.
module xxhash64_feeder
  import xxhash_pkg::*;
#(
  parameter int IN_BYTES = 1,
  parameter int LEN_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  xxhash64_feeder_if.slave bus
);

  localparam logic [LEN_W-1:0] LEN_INC = LEN_W'(IN_BYTES);

  state_e           state_q, state_d;
  logic             seed_ready_q, seed_ready_d;
  logic             s_ready_q, s_ready_d;
  logic             seed_in_q, seed_in_d;
  logic             add_to_hash_q, add_to_hash_d;
  logic             request_hash_q, request_hash_d;
  word_t            input_bytes_q, input_bytes_d;
  logic [3:0]       word_bytes_q, word_bytes_d;
  logic             res_valid_q, res_valid_d;
  word_t            res_hash_q, res_hash_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic             beat_fire_s;
  logic             word_done_s;
  word_t            word_s;
  logic [3:0]       word_bytes_s;

  assign beat_fire_s = bus.s_valid && s_ready_q;

  xxhash_byte_packer #(
    .IN_BYTES (IN_BYTES)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .beat_fire  (beat_fire_s),
    .beat_data  (bus.s_data),
    .beat_last  (bus.s_last),
    .word_done  (word_done_s),
    .word       (word_s),
    .word_bytes (word_bytes_s)
  );

  // Message FSM: next state, next strobes, length and result capture.
  always_comb begin
    state_d        = state_q;
    seed_in_d      = 1'b0;
    add_to_hash_d  = 1'b0;
    request_hash_d = 1'b0;
    input_bytes_d  = input_bytes_q;
    word_bytes_d   = 4'd0;
    res_valid_d    = res_valid_q;
    res_hash_d     = res_hash_q;
    res_len_d      = res_len_q;
    len_d          = len_q;
    case (state_q)
      IDLE: begin
        if (bus.seed_valid && seed_ready_q) begin
          input_bytes_d = bus.seed;
          seed_in_d     = 1'b1;
          len_d         = {LEN_W{1'b0}};
          state_d       = bus.seed_empty ? REQ : PACK;
        end else begin
          state_d = IDLE;
        end
      end
      PACK: begin
        if (beat_fire_s) begin
          len_d = len_q + LEN_INC;
          if (word_done_s) begin
            add_to_hash_d = 1'b1;
            input_bytes_d = word_s;
            word_bytes_d  = word_bytes_s;
          end else begin
            add_to_hash_d = 1'b0;
          end
          state_d = bus.s_last ? REQ : PACK;
        end else begin
          state_d = PACK;
        end
      end
      REQ: begin
        // Only a hash_ready seen while the request is already up counts;
        // the first REQ cycle is the final add_to_hash / seed_in cycle.
        if (request_hash_q && bus.hash_ready) begin
          res_hash_d     = bus.output_hash;
          res_len_d      = len_q;
          res_valid_d    = 1'b1;
          request_hash_d = 1'b0;
          state_d        = DONE;
        end else begin
          request_hash_d = 1'b1;
          state_d        = REQ;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    seed_ready_d = (state_d == IDLE);
    s_ready_d    = (state_d == PACK);
  end

  // State, strobe, data and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      seed_ready_q   <= 1'b1;
      s_ready_q      <= 1'b0;
      seed_in_q      <= 1'b0;
      add_to_hash_q  <= 1'b0;
      request_hash_q <= 1'b0;
      input_bytes_q  <= {WORD_SIZE{1'b0}};
      word_bytes_q   <= 4'd0;
      res_valid_q    <= 1'b0;
      res_hash_q     <= {WORD_SIZE{1'b0}};
      res_len_q      <= {LEN_W{1'b0}};
      len_q          <= {LEN_W{1'b0}};
    end else begin
      state_q        <= state_d;
      seed_ready_q   <= seed_ready_d;
      s_ready_q      <= s_ready_d;
      seed_in_q      <= seed_in_d;
      add_to_hash_q  <= add_to_hash_d;
      request_hash_q <= request_hash_d;
      input_bytes_q  <= input_bytes_d;
      word_bytes_q   <= word_bytes_d;
      res_valid_q    <= res_valid_d;
      res_hash_q     <= res_hash_d;
      res_len_q      <= res_len_d;
      len_q          <= len_d;
    end
  end

  assign bus.seed_ready   = seed_ready_q;
  assign bus.s_ready      = s_ready_q;
  assign bus.seed_in      = seed_in_q;
  assign bus.add_to_hash  = add_to_hash_q;
  assign bus.request_hash = request_hash_q;
  assign bus.input_bytes  = input_bytes_q;
  assign bus.word_bytes   = word_bytes_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_hash     = res_hash_q;
  assign bus.res_len      = res_len_q;

endmodule

// File: doc/xxhash64_feeder.md
Name: xxhash64_feeder

Overview:
- Upstream stage of the xxhash64 core.
- Accepts one seed per message and then a valid/ready byte stream with a last flag.
- Packs the stream little-endian into 64-bit words and drives the core's seed_in / add_to_hash / request_hash / input_bytes strobes.
- Captures output_hash when hash_ready rises and presents it on a valid/ready result port together with the message length.

Parameters:
- IN_BYTES, 1, bytes per input beat; legal values 1, 2, 4, 8. Every beat is full, so message length is a multiple of IN_BYTES.
- LEN_W, 64, width of the message byte-length counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- seed_valid  in  1  seed offered; starts a message
- seed  in  64  seed value
- seed_empty  in  1  qualifies seed_valid; message has zero bytes
- seed_ready  out  1  feeder idle, seed accepted when seed_valid&&seed_ready
- s_valid  in  1  input beat valid
- s_data  in  8*IN_BYTES  beat data; byte 0 at [7:0] is first in message order
- s_last  in  1  final beat of message
- s_ready  out  1  beat accepted when s_valid&&s_ready
- seed_in  out  1  core strobe: input_bytes holds the seed
- add_to_hash  out  1  core strobe: input_bytes holds a data word
- request_hash  out  1  core: finalise; held until hash_ready
- input_bytes  out  64  core data bus
- word_bytes  out  4  valid bytes in input_bytes during add_to_hash (1..8), low bytes first
- hash_ready  in  1  core: output_hash valid
- output_hash  in  64  core result
- res_valid  out  1  result available
- res_hash  out  64  captured hash
- res_len  out  LEN_W  message length in bytes
- res_ready  in  1  result consumed when res_valid&&res_ready

Behaviour:
- Reset (async, any state, including mid-message): state=IDLE; every output 0 except seed_ready=1; pack buffer, fill count and length cleared. Partial message is discarded.
- All core-side outputs are registered. At most one of seed_in / add_to_hash / request_hash is high in any cycle.
- IDLE:
  - seed_ready=1.
  - On seed accept: input_bytes<=seed, seed_in=1 for exactly the next cycle, len<=0.
  - Next state: REQ if seed_empty, else PACK.
- PACK:
  - s_ready=1.
  - Each accepted beat is written at byte offset fill; fill+=IN_BYTES; len+=IN_BYTES.
  - When fill reaches 8: next cycle add_to_hash=1, input_bytes=packed word, word_bytes=8; buffer cleared in the same cycle. s_ready stays high, so IN_BYTES=8 gives one word per cycle back-to-back.
  - Beat with s_last: emit the remaining word next cycle (full, or partial with word_bytes=fill; unused high bytes 0), then go to REQ. s_ready=0 from the cycle after the last beat is accepted.
  - A last beat that exactly fills the word emits a single word with word_bytes=8; no empty tail word.
  - seed_valid is ignored outside IDLE.
- REQ:
  - request_hash=1 from the cycle after the final add_to_hash (or after seed_in for empty messages), held until hash_ready is sampled 1.
  - On hash_ready: res_hash<=output_hash, res_len<=len, res_valid=1 next cycle, request_hash=0, go to DONE.
  - hash_ready outside REQ is ignored.
- DONE:
  - res_valid held stable until res_ready; then IDLE.
  - res_hash and res_len keep their value until the next capture.
- len wraps modulo 2^LEN_W.

Decomposition:
- Shared package xxhash_pkg:
  - WORD_SIZE=64
  - state enum {IDLE, PACK, REQ, DONE}
  - typedef word_t = logic [63:0]
- Sub-module xxhash_byte_packer: beat-to-word packing, fill count and word_bytes.
- FSM, length counter and result register stay in xxhash64_feeder.

Test Plan:
- IN_BYTES=1, seed 0x0, bytes 0x01..0x08 with last on 0x08 -> one seed_in pulse with input_bytes=0, one add_to_hash with 0x0807060504030201 and word_bytes=8, then request_hash. Core result returned as res_hash, res_len=8.
- IN_BYTES=1, 11 bytes 0x01..0x0B -> words 0x0807060504030201/8 and 0x00000000000B0A09/3, res_len=11, s_ready low from the cycle after the last beat until return to IDLE.
- Seed 0x1234 with seed_empty=1 -> seed_in pulse, no add_to_hash, request_hash the cycle after seed_in, res_len=0.
- IN_BYTES=8, 4 beats with s_valid continuous -> add_to_hash high 4 consecutive cycles with no bubbles, res_len=32; s_valid gaps produce matching add_to_hash gaps.
- res_ready held 0 for 5 cycles after res_valid -> res_valid and res_hash stable, seed_ready=0; seed accepted only after the res_ready handshake.
- rst asserted after 5 of 8 bytes -> all outputs 0 immediately (asynchronous), seed_ready=1. A following 8-byte message hashes identically to the first test.
